// File: rtl/sarray_left_feeder.sv
// Left-edge feeder for a systolic array: accepts one operand vector per cycle and
// skews it so row r sees the vector r+1 cycles after acceptance, with tile tracking.
module sarray_left_feeder #(
   parameter int SARRAY_H             = 64,
   parameter int PE_INPUT_DATA_WIDTH  = 16,
   parameter int TMMA_CNT_WIDTH       = 8,
   parameter int TMMA_PRECISION_WIDTH = 2
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       in_valid_i,
   output logic                                       in_ready_o,
   input  logic                                       in_last_i,
   input  logic                                       in_type_i,
   input  logic [TMMA_PRECISION_WIDTH-1:0]            in_precision_i,
   input  logic [SARRAY_H*PE_INPUT_DATA_WIDTH-1:0]    in_data_i,
   output logic [SARRAY_H-1:0]                        left_in_valid_o,
   output logic [TMMA_CNT_WIDTH*SARRAY_H-1:0]         left_in_cnt_o,
   output logic [SARRAY_H-1:0]                        left_in_type_o,
   output logic [TMMA_PRECISION_WIDTH*SARRAY_H-1:0]   left_in_precision_o,
   output logic [SARRAY_H*PE_INPUT_DATA_WIDTH-1:0]    left_in_data_o,
   output logic                                       tile_done_o
);

   // Handshake: a vector is accepted in any cycle where in_valid_i && in_ready_o;
   // in_ready_o depends only on registered state, never on in_valid_i.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2
   } state_e;

   localparam int DCW = (SARRAY_H > 1) ? $clog2(SARRAY_H) : 1;
   localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(SARRAY_H - 1);

   typedef struct packed {
      logic                            valid;
      logic [TMMA_CNT_WIDTH-1:0]       cnt;
      logic                            typ;
      logic [TMMA_PRECISION_WIDTH-1:0] prec;
   } meta_t;

   state_e                          state_q, state_d;
   logic [DCW-1:0]                  drain_q, drain_d;
   logic [TMMA_CNT_WIDTH-1:0]       idx_q, idx_d;
   logic                            type_q, type_d;
   logic [TMMA_PRECISION_WIDTH-1:0] prec_q, prec_d;
   logic [SARRAY_H-1:0]             last_q;
   logic                            accept;
   logic                            first;
   meta_t                           meta_in;

   assign in_ready_o = (state_q != S_DRAIN);
   assign accept     = in_valid_i && in_ready_o;
   assign first      = (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      idx_d   = idx_q;
      type_d  = type_q;
      prec_d  = prec_q;
      meta_in = '0;

      if (accept) begin
         meta_in.valid = 1'b1;
         meta_in.cnt   = idx_q;
         meta_in.typ   = first ? in_type_i : type_q;
         meta_in.prec  = first ? in_precision_i : prec_q;
         if (first) begin
            type_d = in_type_i;
            prec_d = in_precision_i;
         end
         idx_d = in_last_i ? '0 : idx_q + TMMA_CNT_WIDTH'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = in_last_i ? S_DRAIN : S_STREAM;
               if (in_last_i) drain_d = DRAIN_LOAD;
            end
         end
         S_STREAM: begin
            if (accept && in_last_i) begin
               state_d = S_DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         S_DRAIN: begin
            // Leave as the counter steps down to 0, so the feeder stalls for
            // SARRAY_H-1 cycles (a single cycle when SARRAY_H is 1).
            if (drain_q <= DCW'(1)) begin
               state_d = S_IDLE;
               drain_d = '0;
            end else begin
               drain_d = drain_q - DCW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         drain_q <= '0;
         idx_q   <= '0;
         type_q  <= 1'b0;
         prec_q  <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         idx_q   <= idx_d;
         type_q  <= type_d;
         prec_q  <= prec_d;
      end
   end

   // The last-vector marker travels alongside the row SARRAY_H-1 chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= '0;
      end else begin
         last_q[0] <= accept && in_last_i;
         for (int k = 1; k < SARRAY_H; k++) begin
            last_q[k] <= last_q[k-1];
         end
      end
   end

   assign tile_done_o = last_q[SARRAY_H-1];

   for (genvar r = 0; r < SARRAY_H; r++) begin : g_row
      meta_t                          meta_q [r+1];
      logic [PE_INPUT_DATA_WIDTH-1:0] data_q [r+1];
      logic [PE_INPUT_DATA_WIDTH-1:0] data_in;

      assign data_in = accept ? in_data_i[r*PE_INPUT_DATA_WIDTH +: PE_INPUT_DATA_WIDTH] : '0;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int k = 0; k <= r; k++) begin
               meta_q[k] <= '0;
               data_q[k] <= '0;
            end
         end else begin
            meta_q[0] <= meta_in;
            data_q[0] <= data_in;
            for (int k = 1; k <= r; k++) begin
               meta_q[k] <= meta_q[k-1];
               data_q[k] <= data_q[k-1];
            end
         end
      end

      assign left_in_valid_o[r] = meta_q[r].valid;
      assign left_in_type_o[r]  = meta_q[r].typ;
      assign left_in_cnt_o[r*TMMA_CNT_WIDTH +: TMMA_CNT_WIDTH] = meta_q[r].cnt;
      assign left_in_precision_o[r*TMMA_PRECISION_WIDTH +: TMMA_PRECISION_WIDTH] = meta_q[r].prec;
      assign left_in_data_o[r*PE_INPUT_DATA_WIDTH +: PE_INPUT_DATA_WIDTH] = data_q[r];
   end

endmodule

// File: tb/tb_sarray_left_feeder.sv
// Bench for sarray_left_feeder: cycle table with hand-computed ready/done/valid,
// a small tile model for per-row fields, and a hand sequence for SARRAY_H=1.
module tb_sarray_left_feeder;

   localparam int H  = 4;
   localparam int W  = 8;
   localparam int CW = 8;
   localparam int PW = 2;
   localparam int NV = 53;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_last_i = 1'b0;
   logic          in_type_i = 1'b0;
   logic [PW-1:0] in_precision_i = '0;
   logic [H*W-1:0] in_data_i = '0;

   logic            in_ready;
   logic [H-1:0]    lv;
   logic [CW*H-1:0] lc;
   logic [H-1:0]    lt;
   logic [PW*H-1:0] lp;
   logic [H*W-1:0]  ld;
   logic            done;

   logic            w_ready, w_done;
   logic [H-1:0]    w_lv, w_lt;
   logic [2*H-1:0]  w_lc;
   logic [PW*H-1:0] w_lp;
   logic [H*W-1:0]  w_ld;

   logic          s_ready, s_done, s_lv, s_lt;
   logic [CW-1:0] s_lc;
   logic [PW-1:0] s_lp;
   logic [W-1:0]  s_ld;

   sarray_left_feeder #(.SARRAY_H(H), .PE_INPUT_DATA_WIDTH(W), .TMMA_CNT_WIDTH(CW),
                        .TMMA_PRECISION_WIDTH(PW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready),
      .in_last_i(in_last_i), .in_type_i(in_type_i), .in_precision_i(in_precision_i),
      .in_data_i(in_data_i), .left_in_valid_o(lv), .left_in_cnt_o(lc),
      .left_in_type_o(lt), .left_in_precision_o(lp), .left_in_data_o(ld),
      .tile_done_o(done));

   sarray_left_feeder #(.SARRAY_H(H), .PE_INPUT_DATA_WIDTH(W), .TMMA_CNT_WIDTH(2),
                        .TMMA_PRECISION_WIDTH(PW)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(w_ready),
      .in_last_i(in_last_i), .in_type_i(in_type_i), .in_precision_i(in_precision_i),
      .in_data_i(in_data_i), .left_in_valid_o(w_lv), .left_in_cnt_o(w_lc),
      .left_in_type_o(w_lt), .left_in_precision_o(w_lp), .left_in_data_o(w_ld),
      .tile_done_o(w_done));

   sarray_left_feeder #(.SARRAY_H(1), .PE_INPUT_DATA_WIDTH(W), .TMMA_CNT_WIDTH(CW),
                        .TMMA_PRECISION_WIDTH(PW)) dut_1 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(s_ready),
      .in_last_i(in_last_i), .in_type_i(in_type_i), .in_precision_i(in_precision_i),
      .in_data_i(in_data_i[W-1:0]), .left_in_valid_o(s_lv), .left_in_cnt_o(s_lc),
      .left_in_type_o(s_lt), .left_in_precision_o(s_lp), .left_in_data_o(s_ld),
      .tile_done_o(s_done));

   typedef struct {
      logic          rst_n;
      logic          v;
      logic          l;
      logic          ty;
      logic [PW-1:0] pr;
      logic [31:0]   data;
      logic          chk;
      logic          er;
      logic          ed;
      logic [H-1:0]  ev;
   } vec_t;

   vec_t tbl [NV];

   int n_checks = 0;
   int n_fail   = 0;

   // Tile model state and acceptance history, indexed by table cycle.
   logic          h_acc  [NV];
   logic [CW-1:0] h_cnt  [NV];
   logic          h_ty   [NV];
   logic [PW-1:0] h_pr   [NV];
   logic [31:0]   h_data [NV];
   logic          m_first;
   logic [CW-1:0] m_idx;
   logic          m_ty;
   logic [PW-1:0] m_pr;

   function automatic vec_t mk(input logic rn, input logic v, input logic l, input logic ty,
                               input logic [PW-1:0] pr, input logic [31:0] data,
                               input logic chk, input logic er, input logic ed,
                               input logic [H-1:0] ev);
      vec_t t;
      t.rst_n = rn; t.v = v; t.l = l; t.ty = ty; t.pr = pr; t.data = data;
      t.chk = chk; t.er = er; t.ed = ed; t.ev = ev;
      return t;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst_n          = t.rst_n;
      in_valid_i     = t.v;
      in_last_i      = t.l;
      in_type_i      = t.ty;
      in_precision_i = t.pr;
      in_data_i      = t.data;
   endtask

   task automatic check_rows(input int i);
      int            idx;
      logic [63:0]   exp_f, act_f;
      logic [1:0]    exp_w;
      for (int r = 0; r < H; r++) begin
         idx = i - 1 - r;
         exp_f = '0;
         exp_w = '0;
         if (idx >= 0 && h_acc[idx]) begin
            exp_f = {45'd0, 1'b1, h_cnt[idx], h_ty[idx], h_pr[idx], h_data[idx][r*W +: W]};
            exp_w = h_cnt[idx][1:0];
         end
         act_f = {45'd0, lv[r], lc[r*CW +: CW], lt[r], lp[r*PW +: PW], ld[r*W +: W]};
         check($sformatf("row%0d fields c%0d", r, i), act_f, exp_f);
         check($sformatf("row%0d wrap cnt c%0d", r, i), 64'(w_lc[r*2 +: 2]), 64'(exp_w));
      end
   endtask

   task automatic model_update(input int i);
      vec_t t;
      t = tbl[i];
      if (!t.rst_n) begin
         for (int j = 0; j <= i; j++) h_acc[j] = 1'b0;
         m_first = 1'b1;
         m_idx   = '0;
         m_ty    = 1'b0;
         m_pr    = '0;
      end else if (t.v && t.er) begin
         if (m_first) begin
            m_ty = t.ty;
            m_pr = t.pr;
         end
         h_acc[i]  = 1'b1;
         h_cnt[i]  = m_first ? '0 : m_idx;
         h_ty[i]   = m_ty;
         h_pr[i]   = m_pr;
         h_data[i] = t.data;
         m_idx     = t.l ? '0 : h_cnt[i] + 8'd1;
         m_first   = t.l;
      end
   endtask

   initial begin
      for (int j = 0; j < NV; j++) begin
         h_acc[j] = 1'b0; h_cnt[j] = '0; h_ty[j] = 1'b0; h_pr[j] = '0; h_data[j] = '0;
      end
      m_first = 1'b1; m_idx = '0; m_ty = 1'b0; m_pr = '0;

      tbl[0]  = mk(0,0,0,0,0,32'h0,       0,1,0,4'b0000);
      tbl[1]  = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0000);
      tbl[2]  = mk(1,1,1,1,3,32'h44332211,1,1,0,4'b0000);
      tbl[3]  = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b0001);
      tbl[4]  = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b0010);
      tbl[5]  = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b0100);
      tbl[6]  = mk(1,0,0,0,0,32'hdeadbeef,1,1,1,4'b1000);
      tbl[7]  = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0000);
      tbl[8]  = mk(1,1,0,0,2,32'h04030201,1,1,0,4'b0000);
      tbl[9]  = mk(1,1,0,1,1,32'h14131211,1,1,0,4'b0001);
      tbl[10] = mk(1,1,1,1,1,32'h24232221,1,1,0,4'b0011);
      tbl[11] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b0111);
      tbl[12] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b1110);
      tbl[13] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b1100);
      tbl[14] = mk(1,0,0,0,0,32'hdeadbeef,1,1,1,4'b1000);
      tbl[15] = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0000);
      tbl[16] = mk(1,1,0,1,0,32'h0d0c0b0a,1,1,0,4'b0000);
      tbl[17] = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0001);
      tbl[18] = mk(1,1,1,0,3,32'h1d1c1b1a,1,1,0,4'b0010);
      tbl[19] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b0101);
      tbl[20] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b1010);
      tbl[21] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b0100);
      tbl[22] = mk(1,0,0,0,0,32'hdeadbeef,1,1,1,4'b1000);
      tbl[23] = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0000);
      tbl[24] = mk(1,1,0,1,2,32'h34333231,1,1,0,4'b0000);
      tbl[25] = mk(1,1,0,1,2,32'h45444342,1,1,0,4'b0001);
      tbl[26] = mk(0,1,0,1,2,32'h56555453,1,1,0,4'b0011);
      tbl[27] = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0000);
      tbl[28] = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0000);
      tbl[29] = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0000);
      tbl[30] = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0000);
      tbl[31] = mk(1,1,0,1,1,32'h61626364,1,1,0,4'b0000);
      tbl[32] = mk(1,1,1,0,0,32'h71727374,1,1,0,4'b0001);
      tbl[33] = mk(1,1,0,0,2,32'h81828384,1,0,0,4'b0011);
      tbl[34] = mk(1,1,0,0,2,32'h81828384,1,0,0,4'b0110);
      tbl[35] = mk(1,1,0,0,2,32'h81828384,1,0,0,4'b1100);
      tbl[36] = mk(1,1,0,0,2,32'h91929394,1,1,1,4'b1000);
      tbl[37] = mk(1,1,1,1,1,32'ha1a2a3a4,1,1,0,4'b0001);
      tbl[38] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b0011);
      tbl[39] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b0110);
      tbl[40] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b1100);
      tbl[41] = mk(1,0,0,0,0,32'hdeadbeef,1,1,1,4'b1000);
      tbl[42] = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0000);
      tbl[43] = mk(1,1,0,1,1,32'hb0b1b2b3,1,1,0,4'b0000);
      tbl[44] = mk(1,1,0,0,2,32'hc0c1c2c3,1,1,0,4'b0001);
      tbl[45] = mk(1,1,0,0,3,32'hd0d1d2d3,1,1,0,4'b0011);
      tbl[46] = mk(1,1,0,1,0,32'he0e1e2e3,1,1,0,4'b0111);
      tbl[47] = mk(1,1,1,0,2,32'hf0f1f2f3,1,1,0,4'b1111);
      tbl[48] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b1111);
      tbl[49] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b1110);
      tbl[50] = mk(1,0,0,0,0,32'hdeadbeef,1,0,0,4'b1100);
      tbl[51] = mk(1,0,0,0,0,32'hdeadbeef,1,1,1,4'b1000);
      tbl[52] = mk(1,0,0,0,0,32'hdeadbeef,1,1,0,4'b0000);

      // Hand sequence: single-row feeder and single-vector tile with explicit values.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      drive(mk(1,1,1,1,3,32'h44332211,0,0,0,4'b0000));
      @(negedge clk);
      check("h1 ready t0", 64'(s_ready), 64'd1);
      check("h4 ready t0", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      drive(mk(1,0,0,0,0,32'hdeadbeef,0,0,0,4'b0000));
      @(negedge clk);
      check("h1 ready t1", 64'(s_ready), 64'd0);
      check("h1 done t1", 64'(s_done), 64'd1);
      check("h1 fields t1", {45'd0, s_lv, s_lc, s_lt, s_lp, s_ld}, {45'd0, 1'b1, 8'd0, 1'b1, 2'd3, 8'h11});
      check("h4 row0 t1", {55'd0, lv[0], ld[7:0]}, {55'd0, 1'b1, 8'h11});
      @(posedge clk); #1;
      @(negedge clk);
      check("h1 ready t2", 64'(s_ready), 64'd1);
      check("h1 done t2", 64'(s_done), 64'd0);
      check("h1 bubble t2", {45'd0, s_lv, s_lc, s_lt, s_lp, s_ld}, 64'd0);
      check("h4 row1 t2", {55'd0, lv[1], ld[15:8]}, {55'd0, 1'b1, 8'h22});
      check("h4 ready t2", 64'(in_ready), 64'd0);

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         drive(tbl[i]);
         @(negedge clk);
         if (tbl[i].chk) begin
            check($sformatf("ready c%0d", i), 64'(in_ready), 64'(tbl[i].er));
            check($sformatf("done c%0d", i), 64'(done), 64'(tbl[i].ed));
            check($sformatf("valid c%0d", i), 64'(lv), 64'(tbl[i].ev));
            check($sformatf("wrap valid c%0d", i), 64'(w_lv), 64'(tbl[i].ev));
            check_rows(i);
         end
         model_update(i);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sarray_left_feeder.md
SARRAY_LEFT_FEEDER -- requirements
Module: sarray_left_feeder

Interface
REQ-001 Parameter SARRAY_H, default 64, number of array rows (skew depth).
REQ-002 Parameter PE_INPUT_DATA_WIDTH, default 16, per-row operand width.
REQ-003 Parameter TMMA_CNT_WIDTH, default 8, vector-index width.
REQ-004 Parameter TMMA_PRECISION_WIDTH, default 2, precision code width.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 in_valid_i  input  1  input vector valid.
REQ-008 in_ready_o  output  1  feeder accepts vector this cycle.
REQ-009 in_last_i  input  1  vector is final one of the tile.
REQ-010 in_type_i  input  1  operand type, sampled on first vector of tile.
REQ-011 in_precision_i  input  TMMA_PRECISION_WIDTH  precision, sampled on first vector of tile.
REQ-012 in_data_i  input  SARRAY_H*PE_INPUT_DATA_WIDTH  one operand per row; row r at bits [r*PE_INPUT_DATA_WIDTH +: PE_INPUT_DATA_WIDTH].
REQ-013 left_in_valid_o  output  SARRAY_H  per-row valid to array left edge.
REQ-014 left_in_cnt_o  output  TMMA_CNT_WIDTH*SARRAY_H  per-row vector index.
REQ-015 left_in_type_o  output  SARRAY_H  per-row type.
REQ-016 left_in_precision_o  output  TMMA_PRECISION_WIDTH*SARRAY_H  per-row precision.
REQ-017 left_in_data_o  output  SARRAY_H*PE_INPUT_DATA_WIDTH  per-row operand.
REQ-018 tile_done_o  output  1  one-cycle pulse: last vector left row SARRAY_H-1.

Function
REQ-019 Handshake: vector accepted iff in_valid_i && in_ready_o in same cycle.
REQ-020 FSM states IDLE, STREAM, DRAIN; in_ready_o = 1 in IDLE and STREAM, 0 in DRAIN.
REQ-021 IDLE->STREAM on accepted vector with in_last_i=0; IDLE->DRAIN on accepted vector with in_last_i=1.
REQ-022 STREAM->DRAIN on accepted vector with in_last_i=1; otherwise stays STREAM, including bubble cycles.
REQ-023 DRAIN: down-counter loaded with SARRAY_H-1 on entry; DRAIN->IDLE when counter reaches 0; tile_done_o pulses in the cycle the last vector is driven on row SARRAY_H-1.
REQ-024 For SARRAY_H=1, DRAIN lasts exactly one cycle, tile_done_o pulses the cycle after acceptance.
REQ-025 Skew: vector accepted at cycle t drives row r outputs (valid, cnt, type, precision, row-r data slice) during cycle t+1+r.
REQ-026 Non-accepted cycles inject a bubble: row r valid=0 at t+1+r; data/cnt/type/precision in bubble slots are don't-care but SHALL be 0.
REQ-027 Skew implemented as per-row shift chain of depth r+1 registers; no combinational path from in_* to left_in_*.
REQ-028 Vector index counter: 0 for first vector of tile, +1 per accepted vector, wraps modulo 2^TMMA_CNT_WIDTH, cleared to 0 after last vector accepted.
REQ-029 type/precision latched on first vector of tile; same values travel with every vector of that tile; first vector uses live inputs.
REQ-030 Back-to-back tiles: next tile's first vector not accepted until FSM back in IDLE; no two tiles' vectors interleave on any row.

Reset
REQ-031 rst_n=0 at a clock edge: FSM->IDLE, all skew registers, counters, latched type/precision cleared to 0.
REQ-032 Reset values: left_in_valid_o=0, left_in_cnt_o=0, left_in_type_o=0, left_in_precision_o=0, left_in_data_o=0, tile_done_o=0, in_ready_o=1 (first cycle after reset released).
REQ-033 Reset mid-tile discards all in-flight vectors; no tile_done_o pulse for the aborted tile.

Verification (SARRAY_H=4, PE_INPUT_DATA_WIDTH=8)
REQ-034 Single vector, in_last_i=1, data 0x44332211 at t=0 -> row0 valid with 0x11 at t=1, row1 0x22 at t=2, row2 0x33 at t=3, row3 0x44 at t=4; tile_done_o at t=4; in_ready_o=0 t=1..3.
REQ-035 Tile of 3 vectors back-to-back, last on 3rd -> row r valid cycles 1+r..3+r with cnt 0,1,2; precision=2 throughout despite in_precision_i changed to 1 on vector 2.
REQ-036 Tile with bubble (vectors at t=0,2, last at t=2) -> row r valid at 1+r and 3+r, 0 at 2+r; cnt 0 then 1.
REQ-037 Reset asserted at t=2 during 4-vector tile -> all left_in_valid_o=0 from t=3, no tile_done_o, in_ready_o=1 after release.
REQ-038 in_valid_i held high across two tiles -> in_ready_o low exactly 3 cycles between tiles; second tile cnt restarts at 0.
REQ-039 Index wrap with TMMA_CNT_WIDTH=2, 5-vector tile -> cnt sequence 0,1,2,3,0 on every row.
